// File: rtl/demorgan_sweep_checker_pkg.sv
// Shared definitions for the De Morgan gate-block sweep checker.
package demorgan_sweep_checker_pkg;

  // Sequencer states; explicit codes keep the legacy 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit positions of each gate output inside the packed obs bus.
  localparam int unsigned NA      = 0;
  localparam int unsigned NB      = 1;
  localparam int unsigned AB      = 2;
  localparam int unsigned AORB    = 3;
  localparam int unsigned NAANDNB = 4;
  localparam int unsigned NAORB   = 5;
  localparam int unsigned NAORNB  = 6;
  localparam int unsigned NAB     = 7;

  // Width of the mismatch counter.
  localparam int unsigned ERR_W = 8;

endpackage

// File: rtl/demorgan_sweep_checker_golden.sv
// Golden response of the two-input De Morgan gate block for one {A,B} vector.
module demorgan_golden
  import demorgan_sweep_checker_pkg::*;
(
  input  logic [1:0] vec,
  output logic [7:0] expected
);

  logic a;
  logic b;

  assign a = vec[1];
  assign b = vec[0];

  // Expected gate outputs, packed in obs bit order.
  always_comb begin
    expected          = '0;
    expected[NA]      = ~a;
    expected[NB]      = ~b;
    expected[AB]      = a & b;
    expected[AORB]    = a | b;
    expected[NAANDNB] = ~a & ~b;
    expected[NAORB]   = ~(a | b);
    expected[NAORNB]  = ~a | ~b;
    expected[NAB]     = ~(a & b);
  end

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Stimulus/response sequencer: sweeps {A,B} through 00..11 for PASSES sweeps,
// samples the gate outputs after SETTLE cycles and scores them against golden.
module demorgan_sweep_checker
  import demorgan_sweep_checker_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned PASSES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             A,
  output logic             B,
  input  logic [7:0]       obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic [7:0]       first_fail_bits
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [5:0]       LAST_PASS   = 6'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [1:0]       vec;
  logic [3:0]       settle_cnt;
  logic [5:0]       pass_idx;
  logic [7:0]       expected;
  logic [7:0]       mismatch;
  logic             any_fail;
  logic             last_vec;
  logic [ERR_W-1:0] err_next;

  demorgan_golden u_golden (
    .vec      (vec),
    .expected (expected)
  );

  // A/B come straight from the vector register so they only move when vec does.
  assign A = vec[1];
  assign B = vec[0];

  // Scoring of the current vector and saturating next error count.
  always_comb begin
    mismatch = obs ^ expected;
    any_fail = |mismatch;
    last_vec = (vec == 2'b11) && (pass_idx == LAST_PASS);
    err_next = err_count;
    if (any_fail && (err_count != '1)) begin
      err_next = err_count + ERR_ONE;
    end
  end

  // Sequencer, counters and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      vec             <= '0;
      settle_cnt      <= '0;
      pass_idx        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_vec  <= '0;
      first_fail_bits <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state           <= ST_SETTLE;
            vec             <= '0;
            pass_idx        <= '0;
            settle_cnt      <= SETTLE_LOAD;
            err_count       <= '0;
            first_fail_vec  <= '0;
            first_fail_bits <= '0;
            pass            <= 1'b0;
            busy            <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_CHECK: begin
          err_count <= err_next;
          // err_count never returns to zero within a run, so zero means no earlier failure.
          if (any_fail && (err_count == '0)) begin
            first_fail_vec  <= vec;
            first_fail_bits <= mismatch;
          end
          if (last_vec) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            vec        <= vec + 2'd1;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_SETTLE;
            if (vec == 2'b11) begin
              pass_idx <= pass_idx + 6'd1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Bench for demorgan_sweep_checker: three parameterisations, a fault-injectable
// gate-block model, and a cycle-by-cycle reference of the expected sweep.
module tb_demorgan_sweep_checker;

  localparam int unsigned ST_TAB [3] = '{1, 1, 3};
  localparam int unsigned PS_TAB [3] = '{1, 2, 1};
  // Truth table of the gate block per {A,B}, packed {nAB,...,nA}.
  localparam logic [7:0] GOLD [4] = '{8'hF3, 8'hC9, 8'hCA, 8'h0C};

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start;
  logic [2:0] a_s, b_s, busy_s, done_s, pass_s;
  logic [7:0] obs  [3];
  logic [7:0] errc [3];
  logic [7:0] ffb  [3];
  logic [1:0] ffv  [3];
  logic [7:0] s0   [3];
  logic [7:0] s1   [3];
  logic [7:0] junk [3];
  logic [2:0] glitch;

  int checks = 0;
  int errors = 0;
  int run_id = 0;
  int seen_id = 0;
  int fin_id = 0;
  int cur = 0;
  int k = 0;
  bit mon = 1'b0;
  bit abort = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    demorgan_sweep_checker #(
      .SETTLE (ST_TAB[g]),
      .PASSES (PS_TAB[g])
    ) u_dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start[g]),
      .A               (a_s[g]),
      .B               (b_s[g]),
      .obs             (obs[g]),
      .busy            (busy_s[g]),
      .done            (done_s[g]),
      .pass            (pass_s[g]),
      .err_count       (errc[g]),
      .first_fail_vec  (ffv[g]),
      .first_fail_bits (ffb[g])
    );
  end

  // Gate block model with stuck-at-0/1 masks and an optional glitch overlay.
  always_comb begin
    for (int g = 0; g < 3; g++) begin
      obs[g] = ((GOLD[{a_s[g], b_s[g]}] | s1[g]) & ~s0[g]) ^ (glitch[g] ? junk[g] : 8'h00);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_diff(input int v, input int g);
    logic [7:0] o;
    o = (GOLD[v] | s1[g]) & ~s0[g];
    return int'(o ^ GOLD[v]);
  endfunction

  // Reference: after edge k of a run, derive every output from the sweep schedule.
  always @(negedge clk) begin
    int s, p, n, m, e, fv, fb, d, vexp;
    if (run_id != seen_id) begin
      seen_id = run_id;
      k = 0;
      mon = 1'b1;
    end
    if (mon && abort) begin
      mon = 1'b0;
      fin_id = run_id;
    end else if (mon) begin
      s = ST_TAB[cur] + 1;
      p = PS_TAB[cur];
      n = 4 * p * s;
      m = ((k < n) ? k : n) / s;
      e = 0; fv = 0; fb = 0;
      for (int j = 0; j < m; j++) begin
        d = model_diff(j % 4, cur);
        if (d != 0) begin
          if (e == 0) begin
            fv = j % 4;
            fb = d;
          end
          e++;
        end
      end
      if (e > 255) e = 255;
      vexp = (k < n) ? (k / s) % 4 : 3;
      chk("A", a_s[cur], vexp / 2);
      chk("B", b_s[cur], vexp % 2);
      chk("busy", busy_s[cur], int'(k < n));
      chk("done", done_s[cur], int'(k == n));
      chk("pass", pass_s[cur], int'((k >= n) && (e == 0)));
      chk("err_count", errc[cur], e);
      chk("first_fail_vec", ffv[cur], fv);
      chk("first_fail_bits", ffb[cur], fb);
      k++;
      if (k > n + 1) begin
        mon = 1'b0;
        fin_id = run_id;
      end
    end
  end

  task automatic check_reset(input int g);
    chk("rst_A", a_s[g], 0);
    chk("rst_B", b_s[g], 0);
    chk("rst_busy", busy_s[g], 0);
    chk("rst_done", done_s[g], 0);
    chk("rst_pass", pass_s[g], 0);
    chk("rst_err_count", errc[g], 0);
    chk("rst_first_fail_vec", ffv[g], 0);
    chk("rst_first_fail_bits", ffb[g], 0);
  endtask

  // One run on instance g; optional extra start pulse sampled at edge restart_at,
  // optional reset sampled at edge reset_at (edges counted from the accepting edge).
  task automatic do_run(input int g, input bit glit, input int restart_at, input int reset_at);
    int n;
    bit ended;
    n = 4 * PS_TAB[g] * (ST_TAB[g] + 1);
    ended = 1'b0;
    cur = g;
    @(posedge clk); #1;
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    run_id++;
    for (int t = 0; t < n + 8; t++) begin
      glitch[g] = glit && (t < n) && (t % (ST_TAB[g] + 1) == 0);
      junk[g] = 8'($urandom_range(1, 255));
      if (t == restart_at - 1) start[g] = 1'b1;
      if (t == restart_at) start[g] = 1'b0;
      if (t == reset_at - 1) begin
        reset = 1'b1;
        abort = 1'b1;
      end
      if (t == reset_at) begin
        check_reset(g);
        reset = 1'b0;
        abort = 1'b0;
        ended = 1'b1;
        break;
      end
      if (fin_id == run_id) begin
        ended = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    glitch[g] = 1'b0;
    start[g] = 1'b0;
    chk("run_completed", int'(ended), 1);
  endtask

  initial begin
    reset = 1'b1;
    start = '0;
    glitch = '0;
    for (int g = 0; g < 3; g++) begin
      s0[g] = '0;
      s1[g] = '0;
      junk[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) check_reset(g);
    reset = 1'b0;

    // Fault-free, defaults.
    do_run(0, 1'b0, -1, -1);
    chk("ff_pass", pass_s[0], 1);
    chk("ff_err", errc[0], 0);
    chk("ff_vec", ffv[0], 0);
    chk("ff_bits", ffb[0], 0);

    // nAB stuck-at-0, defaults.
    s0[0] = 8'h80;
    do_run(0, 1'b0, -1, -1);
    chk("nab_err", errc[0], 3);
    chk("nab_pass", pass_s[0], 0);
    chk("nab_vec", ffv[0], 0);
    chk("nab_bits", ffb[0], 8'h80);

    // nAB stuck-at-0, two passes.
    s0[1] = 8'h80;
    do_run(1, 1'b0, -1, -1);
    chk("nab2_err", errc[1], 6);
    chk("nab2_vec", ffv[1], 0);
    s0[1] = '0;

    // Longer settle with glitches during the first settle cycle.
    do_run(2, 1'b1, -1, -1);
    chk("settle3_pass", pass_s[2], 1);
    chk("settle3_err", errc[2], 0);

    // Extra start while busy, then start while in DONE: both ignored.
    s0[0] = '0;
    do_run(0, 1'b0, 3, -1);
    do_run(0, 1'b0, 9, -1);

    // Reset mid-run of a faulty sweep, then a clean fresh run.
    s0[0] = 8'h80;
    do_run(0, 1'b0, -1, 5);
    s0[0] = '0;
    do_run(0, 1'b0, -1, -1);
    chk("fresh_err", errc[0], 0);
    chk("fresh_pass", pass_s[0], 1);

    // Randomised fault masks, glitches and gaps on all instances.
    for (int r = 0; r < 12; r++) begin
      int g;
      g = int'($urandom_range(0, 2));
      s0[g] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      s1[g] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_run(g, 1'($urandom_range(0, 1)), -1, -1);
      s0[g] = '0;
      s1[g] = '0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
